ofm_axi_write_master: RTL and testbench

AXI4 memory-mapped write master that drains the 512-bit OFM AXI-stream produced by the conv engine's output flattener into global memory.
It is the responder to the flattener's req/done handshake (wmst_req, wmst_addr offset, wmst_xfer_size, wmst_done).
It splits each transfer into INCR bursts that never cross a 4 KB boundary, with several AW bursts in flight.
It reports completion only after every B response has returned.

---
 rtl/ofm_wr_pkg.sv | 18 +
 rtl/ofm_wr_len_fifo.sv | 44 ++++
 rtl/ofm_axi_write_master.sv | 199 +++++++++++++++++++
 tb/tb_ofm_axi_write_master.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_wr_pkg.sv
// Shared constants and FSM encoding for the OFM AXI4 write master.
// Imported by the top and the burst-length FIFO.
package ofm_wr_pkg;

  localparam logic [2:0] AXSIZE_64B = 3'd6;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int BEAT_BYTES = 64;
  localparam int PAGE_BYTES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_FLUSH
  } wr_state_e;

endpackage

// File: rtl/ofm_wr_len_fifo.sv
// Burst-length FIFO between AW issue and W drain.
// Extra pointer bit separates full from empty; DEPTH must be a power of 2 >= 2.
module ofm_wr_len_fifo
  import ofm_wr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wp;
  logic [PW:0]      rp;

  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) &&
                 (wp[PW-1:0] == rp[PW-1:0]);
  assign dout  = mem[rp[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[PW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/ofm_axi_write_master.sv
// AXI4 write master draining the 512-bit OFM stream into memory.
// Bursts are page-clipped; completion waits for every B response.
module ofm_axi_write_master
  import ofm_wr_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_BURST_LEN   = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic [ADDR_WIDTH-1:0]   addr_base,
  input  logic [ADDR_WIDTH-1:0]   offset,
  input  logic [ADDR_WIDTH-1:0]   xfer_size,
  output logic                    done,
  output logic                    busy,
  output logic                    err,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp
);

  localparam int BW = ADDR_WIDTH - 6;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);
  localparam logic [8:0]    MBL    = 9'(MAX_BURST_LEN);

  wr_state_e       state;
  wr_state_e       state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [BW-1:0]   beats_aw;
  logic [BW-1:0]   beats_w;
  logic [OW-1:0]   outst;
  logic [8:0]      w_cnt;
  logic            w_active;
  logic            accept;
  logic            aw_hs;
  logic            w_hs;
  logic            b_hs;
  logic            aw_raise;
  logic            pop;
  logic [12:0]     page_room;
  logic [8:0]      cap;
  logic [8:0]      len;
  logic [8:0]      aw_beats;
  logic [8:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic            unused_size;

  assign unused_size = ^xfer_size[5:0];

  assign m_awsize  = AXSIZE_64B;
  assign m_awburst = BURST_INCR;
  assign m_wstrb   = '1;
  assign m_wdata   = s_tdata;
  assign m_wvalid  = s_tvalid & w_active;
  assign s_tready  = m_wready & w_active;
  assign m_wlast   = w_active & (w_cnt == 9'd1);
  assign busy      = (state != ST_IDLE);
  assign m_bready  = busy;

  assign accept   = (state == ST_IDLE) && req;
  assign aw_hs    = m_awvalid & m_awready;
  assign w_hs     = m_wvalid & m_wready;
  assign b_hs     = m_bvalid & m_bready;
  assign pop      = !w_active && !fifo_empty;
  assign aw_beats = {1'b0, m_awlen} + 9'd1;

  // Largest burst that stays inside the current 4 KB page
  always_comb begin
    page_room = 13'(PAGE_BYTES) - {1'b0, cur_addr[11:0]};
    cap = ({2'b0, page_room[12:6]} < MBL) ?
          {2'b0, page_room[12:6]} : MBL;
    len = (beats_aw < BW'(cap)) ? beats_aw[8:0] : cap;
  end

  assign aw_raise = (state == ST_ACTIVE) && !m_awvalid &&
                    (beats_aw != '0) && (outst < MAX_OS) &&
                    !fifo_full;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req)
          state_nxt = (xfer_size[ADDR_WIDTH-1:6] == '0) ?
                      ST_FLUSH : ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (beats_aw == '0 && beats_w == '0)
          state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (outst == '0) begin
          state_nxt = ST_IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_addr <= '0;
      beats_aw <= '0;
      beats_w  <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cur_addr <= addr_base + offset;
        beats_aw <= xfer_size[ADDR_WIDTH-1:6];
        beats_w  <= xfer_size[ADDR_WIDTH-1:6];
        err      <= 1'b0;
      end else begin
        if (aw_hs) begin
          cur_addr <= cur_addr + (ADDR_WIDTH'(aw_beats) << 6);
          beats_aw <= beats_aw - BW'(aw_beats);
        end
        if (w_hs) beats_w <= beats_w - BW'(1);
        if (b_hs && m_bresp != RESP_OKAY) err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_awvalid <= 1'b0;
      m_awaddr  <= '0;
      m_awlen   <= '0;
    end else if (aw_raise) begin
      m_awvalid <= 1'b1;
      m_awaddr  <= cur_addr;
      m_awlen   <= 8'(len - 9'd1);
    end else if (aw_hs) begin
      m_awvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else begin
      unique case (1'b1)
        aw_hs && !b_hs: outst <= outst + OW'(1);
        b_hs && !aw_hs: outst <= outst - OW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_active <= 1'b0;
      w_cnt    <= '0;
    end else if (pop) begin
      w_active <= 1'b1;
      w_cnt    <= fifo_dout;
    end else if (w_hs) begin
      w_cnt <= w_cnt - 9'd1;
      if (w_cnt == 9'd1) w_active <= 1'b0;
    end
  end

  ofm_wr_len_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (9)
  ) u_len_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (aw_hs),
    .din   (aw_beats),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_ofm_axi_write_master.sv
// Directed bench for ofm_axi_write_master with a behavioural AXI slave
// and stream source; expected values are hand-derived per scenario.
module tb_ofm_axi_write_master;

  localparam int AW = 64;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic [AW-1:0] addr_base;
  logic [AW-1:0] offset;
  logic [AW-1:0] xfer_size;
  logic          done;
  logic          busy;
  logic          err;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic          m_awvalid;
  logic          m_awready;
  logic [AW-1:0] m_awaddr;
  logic [7:0]    m_awlen;
  logic [2:0]    m_awsize;
  logic [1:0]    m_awburst;
  logic          m_wvalid;
  logic          m_wready;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic          m_wlast;
  logic          m_bvalid;
  logic          m_bready;
  logic [1:0]    m_bresp;

  always #5 clk = ~clk;

  ofm_axi_write_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr_base (addr_base),
    .offset    (offset),
    .xfer_size (xfer_size),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_awaddr  (m_awaddr),
    .m_awlen   (m_awlen),
    .m_awsize  (m_awsize),
    .m_awburst (m_awburst),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wlast   (m_wlast),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_bresp   (m_bresp)
  );

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int aw_n, w_n, wlast_n, b_n, src_n;
  int done_n, done_cyc, last_b_cyc, acc_cyc, busy_n;
  int outst, max_out, proto_err, wl_err, data_err;
  int w_burst, w_in_b;
  int b_delay = 1;
  int bad_b = -1;
  int aw_block_at = -1;
  int aw_block_cyc = 0;
  bit gaps = 1'b0;
  logic [AW-1:0] aw_addr_q [$];
  int aw_len_q [$];
  int b_due [$];

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(i);
    return {16{w}};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    aw_n = 0; w_n = 0; wlast_n = 0; b_n = 0; src_n = 0;
    done_n = 0; done_cyc = -1; last_b_cyc = -1;
    acc_cyc = -1; busy_n = 0; outst = 0; max_out = 0;
    proto_err = 0; wl_err = 0; data_err = 0;
    w_burst = 0; w_in_b = 0;
    aw_addr_q.delete(); aw_len_q.delete(); b_due.delete();
    b_delay = 1; bad_b = -1; aw_block_at = -1;
    aw_block_cyc = 0; gaps = 1'b0;
  endtask

  // Slave + stream source: drive at negedge, observe handshakes 1ns later
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) b_due.delete();
    if (aw_n == aw_block_at && aw_block_cyc > 0) begin
      m_awready = 1'b0;
      aw_block_cyc--;
    end else begin
      m_awready = 1'b1;
    end
    m_wready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
    s_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
    s_tdata  = pat(src_n);
    m_bvalid = (b_due.size() > 0) && (b_due[0] <= cyc);
    m_bresp  = (b_n == bad_b) ? 2'b10 : 2'b00;
    #1;
    if (busy) busy_n++;
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (req && !busy) acc_cyc = cyc;
    if (m_awvalid && m_awready) begin
      aw_addr_q.push_back(m_awaddr);
      aw_len_q.push_back(int'(m_awlen));
      aw_n++;
      outst++;
      if (outst > max_out) max_out = outst;
      if (m_awsize !== 3'd6 || m_awburst !== 2'b01) proto_err++;
      if (int'(m_awaddr[11:0]) + (int'(m_awlen) + 1) * 64 > 4096)
        proto_err++;
    end
    if (m_wvalid && m_wready) begin
      if (!(s_tvalid && s_tready)) proto_err++;
      if (m_wdata !== pat(src_n) || m_wstrb !== '1) data_err++;
      src_n++;
      w_n++;
      if (m_wlast) wlast_n++;
      if (w_burst >= aw_len_q.size()) begin
        wl_err++;
      end else begin
        w_in_b++;
        if (m_wlast !== (w_in_b == aw_len_q[w_burst] + 1)) wl_err++;
        if (w_in_b == aw_len_q[w_burst] + 1) begin
          w_burst++;
          w_in_b = 0;
          b_due.push_back(cyc + b_delay);
        end
      end
    end else if (s_tvalid && s_tready) begin
      proto_err++;
    end
    if (m_bvalid && m_bready) begin
      void'(b_due.pop_front());
      b_n++;
      outst--;
      last_b_cyc = cyc;
    end
  end

  task automatic go(input logic [AW-1:0] b,
                    input logic [AW-1:0] o,
                    input logic [AW-1:0] sz);
    @(negedge clk);
    addr_base = b;
    offset    = o;
    xfer_size = sz;
    req       = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k = 0;
    while (done_n == 0 && k < lim) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk(tag, 64'(done_n > 0), 64'd1);
    repeat (3) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_flags"},
        64'({busy, done, err, m_awvalid, m_wvalid,
             m_wlast, s_tready, m_bready}), 64'd0);
    chk({tag, "_awaddr"}, m_awaddr, 64'd0);
    chk({tag, "_awlen"}, 64'(m_awlen), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b0;
    addr_base = '0;
    offset = '0;
    xfer_size = '0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    m_awready = 1'b0;
    m_wready = 1'b0;
    m_bvalid = 1'b0;
    m_bresp = 2'b00;
    clr();
    #7;
    chk_rst("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single full-page burst
    @(negedge clk); #2; clr();
    go(64'h1000, 64'h0, 64'd4096);
    wait_done("t1_done", 400);
    chk("t1_done_n", 64'(done_n), 64'd1);
    chk("t1_aw_n", 64'(aw_n), 64'd1);
    chk("t1_awaddr", aw_addr_q[0], 64'h1000);
    chk("t1_awlen", 64'(aw_len_q[0]), 64'd63);
    chk("t1_beats", 64'(w_n), 64'd64);
    chk("t1_wlast_n", 64'(wlast_n), 64'd1);
    chk("t1_wl_err", 64'(wl_err), 64'd0);
    chk("t1_done_lat", 64'(done_cyc - last_b_cyc), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_err", 64'(err), 64'd0);

    // awready stalls and slow B: outstanding cap
    @(negedge clk); #2; clr();
    b_delay = 20;
    aw_block_at = 4;
    aw_block_cyc = 40;
    go(64'h10000, 64'h0, 64'd19200);
    wait_done("t4_done", 3000);
    chk("t4_max_out", 64'(max_out), 64'd4);
    chk("t4_aw_n", 64'(aw_n), 64'd5);
    chk("t4_last_len", 64'(aw_len_q[4]), 64'd43);
    chk("t4_beats", 64'(w_n), 64'd300);
    chk("t4_wlast_n", 64'(wlast_n), 64'd5);
    chk("t4_b_n", 64'(b_n), 64'd5);
    chk("t4_done_lat", 64'(done_cyc - last_b_cyc), 64'd1);
    chk("t4_proto", 64'(proto_err), 64'd0);

    // random stream/wready gaps, data order
    @(negedge clk); #2; clr();
    gaps = 1'b1;
    go(64'h20000, 64'h0, 64'd8192);
    wait_done("t5_done", 3000);
    chk("t5_aw_n", 64'(aw_n), 64'd2);
    chk("t5_beats", 64'(w_n), 64'd128);
    chk("t5_wlast_aw", 64'(wlast_n), 64'(aw_n));
    chk("t5_data", 64'(data_err), 64'd0);
    chk("t5_wl_err", 64'(wl_err), 64'd0);

    // SLVERR on the second of three bursts
    @(negedge clk); #2; clr();
    bad_b = 1;
    b_delay = 3;
    go(64'h30000, 64'h0, 64'd12288);
    wait_done("t6_done", 1000);
    chk("t6_aw_n", 64'(aw_n), 64'd3);
    chk("t6_err", 64'(err), 64'd1);
    repeat (5) @(negedge clk);
    #2;
    chk("t6_err_hold", 64'(err), 64'd1);

    // zero-size request also clears err
    clr();
    go(64'h5000, 64'h0, 64'd0);
    #2;
    chk("t3_err_clr", 64'(err), 64'd0);
    wait_done("t3_done", 10);
    chk("t3_done_n", 64'(done_n), 64'd1);
    chk("t3_done_lat", 64'(done_cyc - acc_cyc), 64'd1);
    chk("t3_busy_n", 64'(busy_n), 64'd1);
    chk("t3_traffic", 64'(aw_n + w_n), 64'd0);

    // asynchronous reset in the middle of a burst
    @(negedge clk); #2; clr();
    go(64'h40000, 64'h0, 64'd4096);
    begin
      int k = 0;
      while (w_n < 10 && k < 500) begin
        @(negedge clk);
        #2;
        k++;
      end
    end
    chk("rst_mid_reach", 64'(w_n >= 10), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_rst("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // page-crossing split, also recovery after reset
    @(negedge clk); #2; clr();
    go(64'h0, 64'hF80, 64'd512);
    wait_done("t2_done", 400);
    chk("t2_aw_n", 64'(aw_n), 64'd2);
    chk("t2_addr0", aw_addr_q[0], 64'hF80);
    chk("t2_len0", 64'(aw_len_q[0]), 64'd1);
    chk("t2_addr1", aw_addr_q[1], 64'h1000);
    chk("t2_len1", 64'(aw_len_q[1]), 64'd5);
    chk("t2_beats", 64'(w_n), 64'd8);
    chk("t2_wlast_n", 64'(wlast_n), 64'd2);
    chk("t2_proto", 64'(proto_err), 64'd0);
    chk("t2_data", 64'(data_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
